// File: rtl/dmu_sii_pkg.sv
// DMU->SII arbiter shared types and constants.
// FSM states, source codes, beat counts, header codes.
package dmu_sii_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_PLD
  } state_e;

  typedef enum logic [1:0] {
    SRC_RD  = 2'd0,
    SRC_WR  = 2'd1,
    SRC_MN  = 2'd2,
    SRC_PIO = 2'd3
  } src_e;

  localparam int WR_BEATS = 4;
  localparam int MP_BEATS = 1;

  // {datareq, datareq16, reqbypass}
  localparam logic [2:0] HDR_RD  = 3'b000;
  localparam logic [2:0] HDR_WR  = 3'b100;
  localparam logic [2:0] HDR_MN  = 3'b110;
  localparam logic [2:0] HDR_PIO = 3'b111;

  function automatic logic [7:0] parity8(input logic [127:0] d);
    logic [7:0] p;
    for (int i = 0; i < 8; i++) p[i] = ^d[16*i +: 16];
    return p;
  endfunction

endpackage

// File: rtl/dmu_sii_credit_ctr.sv
// DMA write credit counter with saturation.
// Sticky error on a credit return beyond the pool size.
module dmu_sii_credit_ctr
  import dmu_sii_pkg::*;
#(
  parameter int WR_CREDITS = 16
) (
  input  logic       iol2clk,
  input  logic       rst,
  input  logic       issue,
  input  logic       ack,
  output logic [4:0] count,
  output logic       err
);

  localparam logic [4:0] MAX = 5'(WR_CREDITS);

  always_ff @(posedge iol2clk or posedge rst) begin
    if (rst) begin
      count <= MAX;
      err   <= 1'b0;
    end else begin
      unique case ({issue, ack})
        2'b10: count <= count - 5'd1;
        2'b01: begin
          if (count == MAX) err <= 1'b1;
          else count <= count + 5'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/dmu_sii_arb.sv
// DMU->SII request arbiter: header/payload sequencer
// with pio > mn > rr(rd, wr) priority and write credits.
module dmu_sii_arb
  import dmu_sii_pkg::*;
#(
  parameter int WR_CREDITS = 16
) (
  input  logic         iol2clk,
  input  logic         rst,
  input  logic         rd_vld,
  input  logic         wr_vld,
  input  logic         mn_vld,
  input  logic         pio_vld,
  input  logic [127:0] rd_hdr,
  input  logic [127:0] wr_hdr,
  input  logic [127:0] mn_hdr,
  input  logic [127:0] pio_hdr,
  input  logic         rd_byp,
  input  logic         wr_byp,
  output logic         rd_gnt,
  output logic         wr_gnt,
  output logic         mn_gnt,
  output logic         pio_gnt,
  output logic         pld_rd,
  output logic [1:0]   pld_src,
  output logic [1:0]   pld_beat,
  input  logic [127:0] pld_data,
  input  logic [15:0]  pld_be,
  input  logic         sii_dmu_wrack_vld,
  output logic         dmu_sii_hdr_vld,
  output logic         dmu_sii_reqbypass,
  output logic         dmu_sii_datareq,
  output logic         dmu_sii_datareq16,
  output logic [127:0] dmu_sii_data,
  output logic [7:0]   dmu_sii_parity,
  output logic [15:0]  dmu_sii_be,
  output logic [4:0]   wr_credits,
  output logic         credit_err
);

  state_e       state_q, state_d;
  src_e         src_q, src_d, win_src;
  logic [1:0]   beat_q, beat_d;
  logic         rr_q, rr_d;
  logic [1:0]   last_beat;
  logic         arb_en, wr_ok, lo, win;
  logic [127:0] data_d;
  logic [15:0]  be_d;
  logic [2:0]   code_d;
  logic         hv_d;

  assign last_beat = (src_q == SRC_WR) ? 2'(WR_BEATS - 1)
                                       : 2'(MP_BEATS - 1);

  assign arb_en = !rst &&
    ((state_q == ST_IDLE) ||
     (state_q == ST_HDR && src_q == SRC_RD) ||
     (state_q == ST_PLD && beat_q == last_beat));

  assign wr_ok = wr_vld && (wr_credits != 5'd0);
  assign lo    = !pio_vld && !mn_vld;

  // rr_q=0 favours rd, rr_q=1 favours wr
  assign pio_gnt = arb_en && pio_vld;
  assign mn_gnt  = arb_en && mn_vld && !pio_vld;
  assign rd_gnt  = arb_en && lo && rd_vld && (!wr_ok || !rr_q);
  assign wr_gnt  = arb_en && lo && wr_ok && (!rd_vld || rr_q);
  assign win     = pio_gnt || mn_gnt || rd_gnt || wr_gnt;

  always_comb begin
    win_src = SRC_RD;
    unique case (1'b1)
      pio_gnt: win_src = SRC_PIO;
      mn_gnt:  win_src = SRC_MN;
      wr_gnt:  win_src = SRC_WR;
      default: win_src = SRC_RD;
    endcase
  end

  assign pld_rd =
    (state_q == ST_HDR && src_q != SRC_RD) ||
    (state_q == ST_PLD && beat_q != last_beat);
  assign pld_src  = pld_rd ? src_q : 2'd0;
  assign pld_beat = (pld_rd && state_q == ST_PLD) ? beat_q + 2'd1
                                                  : 2'd0;

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    beat_d  = beat_q;
    rr_d    = rr_q;
    if (win) begin
      state_d = ST_HDR;
      src_d   = win_src;
      beat_d  = 2'd0;
      if (rd_gnt || wr_gnt) rr_d = !rr_q;
    end else begin
      unique case (state_q)
        ST_IDLE: ;
        ST_HDR: begin
          beat_d  = 2'd0;
          state_d = (src_q == SRC_RD) ? ST_IDLE : ST_PLD;
        end
        ST_PLD: begin
          if (beat_q == last_beat) state_d = ST_IDLE;
          else beat_d = beat_q + 2'd1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    data_d = '0;
    be_d   = '0;
    code_d = '0;
    hv_d   = 1'b0;
    if (win) begin
      hv_d = 1'b1;
      unique case (win_src)
        SRC_PIO: begin data_d = pio_hdr; code_d = HDR_PIO; end
        SRC_MN:  begin data_d = mn_hdr;  code_d = HDR_MN;  end
        SRC_WR:  begin
          data_d = wr_hdr;
          code_d = HDR_WR | {2'b00, wr_byp};
        end
        default: begin
          data_d = rd_hdr;
          code_d = HDR_RD | {2'b00, rd_byp};
        end
      endcase
    end else if (pld_rd) begin
      data_d = pld_data;
      be_d   = (src_q == SRC_WR) ? pld_be : 16'hFFFF;
    end
  end

  always_ff @(posedge iol2clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      src_q   <= SRC_RD;
      beat_q  <= 2'd0;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      beat_q  <= beat_d;
      rr_q    <= rr_d;
    end
  end

  always_ff @(posedge iol2clk or posedge rst) begin
    if (rst) begin
      dmu_sii_hdr_vld   <= 1'b0;
      dmu_sii_datareq   <= 1'b0;
      dmu_sii_datareq16 <= 1'b0;
      dmu_sii_reqbypass <= 1'b0;
      dmu_sii_data      <= '0;
      dmu_sii_parity    <= '0;
      dmu_sii_be        <= '0;
    end else begin
      dmu_sii_hdr_vld   <= hv_d;
      dmu_sii_datareq   <= code_d[2];
      dmu_sii_datareq16 <= code_d[1];
      dmu_sii_reqbypass <= code_d[0];
      dmu_sii_data      <= data_d;
      dmu_sii_parity    <= parity8(data_d);
      dmu_sii_be        <= be_d;
    end
  end

  dmu_sii_credit_ctr #(
    .WR_CREDITS(WR_CREDITS)
  ) u_credit (
    .iol2clk(iol2clk),
    .rst    (rst),
    .issue  (wr_gnt),
    .ack    (sii_dmu_wrack_vld),
    .count  (wr_credits),
    .err    (credit_err)
  );

endmodule

// File: tb/tb_dmu_sii_arb.sv
// Bench for dmu_sii_arb: grant table, hand sequences,
// output scoreboard, credit and reset checks.
module tb_dmu_sii_arb;

  logic         iol2clk = 1'b0;
  logic         rst = 1'b1;
  logic         rd_vld = 0, wr_vld = 0, mn_vld = 0, pio_vld = 0;
  logic         rd_byp = 0, wr_byp = 0;
  logic [127:0] rd_hdr, wr_hdr, mn_hdr, pio_hdr;
  logic         rd_gnt, wr_gnt, mn_gnt, pio_gnt;
  logic         pld_rd;
  logic [1:0]   pld_src, pld_beat;
  logic [127:0] pld_data;
  logic [15:0]  pld_be;
  logic         wrack = 0;
  logic         hv, byp, dq, dq16;
  logic [127:0] data;
  logic [7:0]   par;
  logic [15:0]  be;
  logic [4:0]   cred;
  logic         cerr;

  logic         wr_vld2 = 0, wrack2 = 0;
  logic         d2_rd_gnt, d2_wr_gnt, d2_mn_gnt, d2_pio_gnt, d2_pld_rd;
  logic [1:0]   d2_pld_src, d2_pld_beat;
  logic         d2_hv, d2_byp, d2_dq, d2_dq16;
  logic [127:0] d2_data;
  logic [7:0]   d2_par;
  logic [15:0]  d2_be;
  logic [4:0]   d2_cred;
  logic         d2_err;

  localparam logic [127:0] RD_H  = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [127:0] WR_H  = 128'hA0A0_0B0B_C0C0_0D0D_E0E0_0F0F_1234_5678;
  localparam logic [127:0] MN_H  = 128'hFEDC_BA98_7654_3210_0000_FFFF_0001_8000;
  localparam logic [127:0] PIO_H = 128'h8000_0001_C3C3_3C3C_9999_6666_ABCD_EF01;

  assign rd_hdr = RD_H;
  assign wr_hdr = WR_H;
  assign mn_hdr = MN_H;
  assign pio_hdr = PIO_H;

  typedef struct {
    logic         hv;
    logic [2:0]   code;
    logic [127:0] data;
    logic [15:0]  be;
  } rec_t;

  typedef struct {
    logic [3:0] vld;
    logic       rb;
    logic       wb;
    logic [3:0] eg;
    logic [2:0] ec;
  } vec_t;

  rec_t q[$];
  rec_t mr;
  vec_t tv[11];
  int   total = 0;
  int   bad = 0;

  function automatic logic [127:0] pdat(input logic [1:0] s,
                                        input logic [1:0] b);
    return {32'hC0DE_0000 | 32'(s), 64'h0123_4567_89AB_CDEF, 30'h0, b};
  endfunction

  function automatic logic [15:0] pbe(input logic [1:0] b);
    logic [15:0] v;
    v = 16'h000F << (4 * b);
    return v;
  endfunction

  function automatic logic [7:0] epar(input logic [127:0] d);
    logic [7:0] p;
    p = '0;
    for (int i = 0; i < 128; i++) p[i/16] = p[i/16] ^ d[i];
    return p;
  endfunction

  assign pld_data = pdat(pld_src, pld_beat);
  assign pld_be   = pbe(pld_beat);

  always #5 iol2clk = ~iol2clk;

  dmu_sii_arb #(.WR_CREDITS(16)) dut (
    .iol2clk(iol2clk), .rst(rst),
    .rd_vld(rd_vld), .wr_vld(wr_vld), .mn_vld(mn_vld), .pio_vld(pio_vld),
    .rd_hdr(rd_hdr), .wr_hdr(wr_hdr), .mn_hdr(mn_hdr), .pio_hdr(pio_hdr),
    .rd_byp(rd_byp), .wr_byp(wr_byp),
    .rd_gnt(rd_gnt), .wr_gnt(wr_gnt), .mn_gnt(mn_gnt), .pio_gnt(pio_gnt),
    .pld_rd(pld_rd), .pld_src(pld_src), .pld_beat(pld_beat),
    .pld_data(pld_data), .pld_be(pld_be),
    .sii_dmu_wrack_vld(wrack),
    .dmu_sii_hdr_vld(hv), .dmu_sii_reqbypass(byp),
    .dmu_sii_datareq(dq), .dmu_sii_datareq16(dq16),
    .dmu_sii_data(data), .dmu_sii_parity(par), .dmu_sii_be(be),
    .wr_credits(cred), .credit_err(cerr)
  );

  dmu_sii_arb #(.WR_CREDITS(2)) dut2 (
    .iol2clk(iol2clk), .rst(rst),
    .rd_vld(1'b0), .wr_vld(wr_vld2), .mn_vld(1'b0), .pio_vld(1'b0),
    .rd_hdr(rd_hdr), .wr_hdr(wr_hdr), .mn_hdr(mn_hdr), .pio_hdr(pio_hdr),
    .rd_byp(1'b0), .wr_byp(1'b0),
    .rd_gnt(d2_rd_gnt), .wr_gnt(d2_wr_gnt), .mn_gnt(d2_mn_gnt),
    .pio_gnt(d2_pio_gnt),
    .pld_rd(d2_pld_rd), .pld_src(d2_pld_src), .pld_beat(d2_pld_beat),
    .pld_data(pld_data), .pld_be(pld_be),
    .sii_dmu_wrack_vld(wrack2),
    .dmu_sii_hdr_vld(d2_hv), .dmu_sii_reqbypass(d2_byp),
    .dmu_sii_datareq(d2_dq), .dmu_sii_datareq16(d2_dq16),
    .dmu_sii_data(d2_data), .dmu_sii_parity(d2_par), .dmu_sii_be(d2_be),
    .wr_credits(d2_cred), .credit_err(d2_err)
  );

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic push_xfer(input logic [3:0] g, input logic [2:0] c);
    if (g[3]) begin
      q.push_back('{1'b1, c, PIO_H, 16'h0});
      q.push_back('{1'b0, 3'b000, pdat(2'd3, 2'd0), 16'hFFFF});
    end
    if (g[2]) begin
      q.push_back('{1'b1, c, MN_H, 16'h0});
      q.push_back('{1'b0, 3'b000, pdat(2'd2, 2'd0), 16'hFFFF});
    end
    if (g[1]) q.push_back('{1'b1, c, RD_H, 16'h0});
    if (g[0]) begin
      q.push_back('{1'b1, c, WR_H, 16'h0});
      for (int b = 0; b < 4; b++)
        q.push_back('{1'b0, 3'b000, pdat(2'd1, 2'(b)), pbe(2'(b))});
    end
  endtask

  // check grants this cycle, queue the resulting output stream
  task automatic gstep(input logic [3:0] eg, input logic [2:0] ec,
                       input string nm);
    @(negedge iol2clk);
    chk(nm, {pio_gnt, mn_gnt, rd_gnt, wr_gnt}, eg);
    push_xfer(eg, ec);
    @(posedge iol2clk);
    #1;
  endtask

  function automatic logic [2:0] codef(input logic [3:0] g,
                                       input logic rb, input logic wb);
    if (g[3]) return 3'b111;
    if (g[2]) return 3'b110;
    if (g[1]) return {2'b00, rb};
    if (g[0]) return {2'b10, wb};
    return 3'b000;
  endfunction

  always @(negedge iol2clk) begin
    if (!rst) begin
      total++;
      if (par !== epar(data)) begin
        bad++;
        $display("FAIL parity act=%h exp=%h", par, epar(data));
      end
      if (hv || be != 16'h0) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_out hv=%0d data=%h be=%h", hv, data, be);
        end else begin
          mr = q.pop_front();
          if ({hv, dq, dq16, byp, data, be} !==
              {mr.hv, mr.code, mr.data, mr.be}) begin
            bad++;
            $display("FAIL out act=%0d/%b/%h/%h exp=%0d/%b/%h/%h",
                     hv, {dq, dq16, byp}, data, be,
                     mr.hv, mr.code, mr.data, mr.be);
          end
        end
      end else begin
        total++;
        if (data != '0 || {dq, dq16, byp} != 3'b000) begin
          bad++;
          $display("FAIL idle_out data=%h code=%b exp 0", data, {dq, dq16, byp});
        end
      end
    end
  end

  logic [3:0] bg[16];
  int n;

  initial begin
    tv[0]  = '{4'b0010, 1'b0, 1'b0, 4'b0010, 3'b000};
    tv[1]  = '{4'b0001, 1'b0, 1'b1, 4'b0001, 3'b101};
    tv[2]  = '{4'b0011, 1'b0, 1'b0, 4'b0010, 3'b000};
    tv[3]  = '{4'b0011, 1'b0, 1'b0, 4'b0001, 3'b100};
    tv[4]  = '{4'b0111, 1'b0, 1'b0, 4'b0100, 3'b110};
    tv[5]  = '{4'b1111, 1'b1, 1'b1, 4'b1000, 3'b111};
    tv[6]  = '{4'b0011, 1'b1, 1'b1, 4'b0010, 3'b001};
    tv[7]  = '{4'b1001, 1'b0, 1'b0, 4'b1000, 3'b111};
    tv[8]  = '{4'b0110, 1'b0, 1'b0, 4'b0100, 3'b110};
    tv[9]  = '{4'b0011, 1'b1, 1'b0, 4'b0001, 3'b100};
    tv[10] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 3'b000};
    bg = '{4'b1000, 4'b0000, 4'b0100, 4'b0000, 4'b0001, 4'b0000,
           4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0001, 4'b0000,
           4'b0000, 4'b0000, 4'b0000, 4'b0000};

    repeat (3) @(posedge iol2clk);
    #1 rst = 1'b0;
    @(negedge iol2clk);
    chk("rst_credits", cred, 5'd16);
    chk("rst_err", cerr, 1'b0);
    chk("rst_out", {hv, dq, dq16, byp, be, data}, '0);
    chk("rst_gnt", {pio_gnt, mn_gnt, rd_gnt, wr_gnt, pld_rd}, '0);
    @(posedge iol2clk);
    #1;

    for (int i = 0; i < 11; i++) begin
      {pio_vld, mn_vld, rd_vld, wr_vld} = tv[i].vld;
      rd_byp = tv[i].rb;
      wr_byp = tv[i].wb;
      gstep(tv[i].eg, tv[i].ec, "tbl_gnt");
      {pio_vld, mn_vld, rd_vld, wr_vld} = 4'b0;
      repeat (6) @(posedge iol2clk);
      #1;
    end
    chk("tbl_credits", cred, 5'd13);

    rd_vld = 1'b1;
    rd_byp = 1'b1;
    for (int i = 0; i < 3; i++) gstep(4'b0010, 3'b001, "rd_b2b");
    rd_vld = 1'b0;
    gstep(4'b0000, 3'b000, "rd_b2b_end");
    chk("rd_credits", cred, 5'd13);
    repeat (2) @(posedge iol2clk);
    #1;

    {pio_vld, mn_vld, rd_vld, wr_vld} = 4'b1111;
    rd_byp = 1'b0;
    wr_byp = 1'b0;
    for (int i = 0; i < 16; i++) begin
      gstep(bg[i], codef(bg[i], 1'b0, 1'b0), "all4_gnt");
      if (i == 0) pio_vld = 1'b0;
      if (i == 2) mn_vld = 1'b0;
      if (i == 10) {rd_vld, wr_vld} = 2'b00;
    end
    repeat (2) @(posedge iol2clk);
    #1;
    chk("all4_credits", cred, 5'd11);

    wrack = 1'b1;
    repeat (5) @(posedge iol2clk);
    #1 wrack = 1'b0;
    @(negedge iol2clk);
    chk("ack_credits", cred, 5'd16);
    chk("ack_err", cerr, 1'b0);
    @(posedge iol2clk);
    #1 wrack = 1'b1;
    @(posedge iol2clk);
    #1 wrack = 1'b0;
    @(negedge iol2clk);
    chk("ovf_err", cerr, 1'b1);
    chk("ovf_credits", cred, 5'd16);
    @(posedge iol2clk);
    #1 wr_vld = 1'b1;
    gstep(4'b0001, 3'b100, "wr_issue");
    wr_vld = 1'b0;
    @(negedge iol2clk);
    chk("issue_credits", cred, 5'd15);
    repeat (6) @(posedge iol2clk);
    #1;
    wr_vld = 1'b1;
    wrack = 1'b1;
    gstep(4'b0001, 3'b100, "wr_issue_ack");
    wr_vld = 1'b0;
    wrack = 1'b0;
    @(negedge iol2clk);
    chk("issue_ack_credits", cred, 5'd15);
    repeat (6) @(posedge iol2clk);
    #1;

    wr_vld2 = 1'b1;
    n = 0;
    repeat (30) begin
      @(negedge iol2clk);
      if (d2_wr_gnt) n++;
    end
    chk("d2_stall_cnt", n, 2);
    chk("d2_credits0", d2_cred, 5'd0);
    @(posedge iol2clk);
    #1 wrack2 = 1'b1;
    @(posedge iol2clk);
    #1 wrack2 = 1'b0;
    repeat (20) begin
      @(negedge iol2clk);
      if (d2_wr_gnt) n++;
    end
    chk("d2_after_ack_cnt", n, 3);
    chk("d2_credits_end", d2_cred, 5'd0);
    wr_vld2 = 1'b0;
    @(posedge iol2clk);
    #1;

    wr_vld = 1'b1;
    gstep(4'b0001, 3'b100, "rst_wr_issue");
    wr_vld = 1'b0;
    repeat (3) @(posedge iol2clk);
    #1 rst = 1'b1;
    q.delete();
    #1;
    chk("midrst_out", {hv, dq, dq16, byp, be, par, data}, '0);
    chk("midrst_pld", {pld_rd, pld_src, pld_beat}, '0);
    chk("midrst_credits", cred, 5'd16);
    repeat (2) @(posedge iol2clk);
    #1 rst = 1'b0;
    @(negedge iol2clk);
    chk("postrst_err", cerr, 1'b0);
    chk("postrst_credits", cred, 5'd16);
    repeat (8) @(posedge iol2clk);
    @(negedge iol2clk);
    chk("sb_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
